// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } pc_state_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/pc_if.sv
// Control/redirect inputs and fetch outputs between the NPC logic and pc_unit.
interface pc_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             call;
  logic             ret;
  logic             exc;
  logic             halt;
  logic             resume;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, br_taken, br_target, call, ret, exc, halt, resume,
    input  pc, pc_valid, ras_empty, ras_full
  );

  modport slave (
    input  stall, br_taken, br_target, call, ret, exc, halt, resume,
    output pc, pc_valid, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_top;
  logic [CW-1:0]    count;
  logic             pop_ok;

  // sp points at the next free slot, which is also the oldest entry when full
  assign sp_top = sp - PW'(1);
  assign pop_ok = pop && (count != '0);
  assign top    = mem[sp_top];
  assign empty  = (count == '0);
  assign full   = (count == CW'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
    end else begin
      unique case ({push, pop_ok})
        2'b10: begin
          mem[sp] <= din;
          sp      <= sp + PW'(1);
          if (count != CW'(RAS_DEPTH)) count <= count + CW'(1);
        end
        2'b01: begin
          sp    <= sp_top;
          count <= count - CW'(1);
        end
        2'b11: mem[sp_top] <= din;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Program counter: next-PC selection, boot/run/halt sequencing and return-address stack.
//   state  | meaning
//   BOOT   | first cycle after reset, pc=RESET_VEC, no fetch
//   RUN    | fetching, pc_valid=1
//   HALTED | pc held, no fetch until resume or exc
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input logic  clk,
  input logic  rst,
  pc_if.slave  bus
);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MASK    = ~(STEP_W - WIDTH'(1));
  localparam logic [WIDTH-1:0] RESET_A = RESET_VEC & MASK;
  localparam logic [WIDTH-1:0] EXC_A   = EXC_VEC & MASK;

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc_seq, ras_top;
  logic             valid_q, push, pop, ras_empty, ras_full;

  assign pc_seq = pc_q + STEP_W;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_seq),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.exc) begin
          pc_d = EXC_A;
        end else if (bus.halt) begin
          state_d = HALTED;
        end else if (!bus.stall) begin
          push = bus.call && bus.br_taken;
          // a ret with an empty stack falls through to branch/sequential
          if (bus.ret && !ras_empty) begin
            pop  = 1'b1;
            pc_d = ras_top & MASK;
          end else if (bus.br_taken) begin
            pc_d = bus.br_target & MASK;
          end else begin
            pc_d = pc_seq;
          end
        end
      end
      HALTED: begin
        if (bus.exc) begin
          state_d = RUN;
          pc_d    = EXC_A;
        end else if (bus.resume) begin
          state_d = RUN;
          pc_d    = pc_seq;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_A;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= (state_d == RUN);
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = valid_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
endmodule

// File: tb/tb_pc_unit.sv
// Directed and random checks of pc_unit against a queue-based reference model.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pc_if #(.WIDTH(32)) bus ();

  pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model: mode 0=boot 1=run 2=halted
  logic [31:0] m_pc;
  int          m_mode;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > 4) void'(m_ras.pop_front());
  endtask

  task automatic model(input logic r, st, bt, input logic [31:0] tg,
                       input logic cl, rt, ex, hl, rs);
    logic [31:0] t;
    if (r) begin
      m_pc = 32'h3000; m_mode = 0; m_ras.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (ex) m_pc = 32'h4180;
      else if (hl) m_mode = 2;
      else if (!st) begin
        if (rt && m_ras.size() > 0) begin
          t = m_ras.pop_back();
          if (cl && bt) m_push(m_pc + 32'd4);
          m_pc = t;
        end else if (bt) begin
          if (cl) m_push(m_pc + 32'd4);
          m_pc = {tg[31:2], 2'b00};
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end else begin
      if (ex) begin m_mode = 1; m_pc = 32'h4180; end
      else if (rs) begin m_mode = 1; m_pc = m_pc + 32'd4; end
    end
  endtask

  task automatic step(input logic r, st, bt, input logic [31:0] tg,
                      input logic cl, rt, ex, hl, rs);
    rst = r; bus.stall = st; bus.br_taken = bt; bus.br_target = tg;
    bus.call = cl; bus.ret = rt; bus.exc = ex; bus.halt = hl; bus.resume = rs;
    @(posedge clk);
    model(r, st, bt, tg, cl, rt, ex, hl, rs);
    #1;
    chk("m_pc", bus.pc, m_pc);
    chk("m_valid", 32'(bus.pc_valid), 32'(m_mode == 1));
    chk("m_empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
    chk("m_full", 32'(bus.ras_full), 32'(m_ras.size() == 4));
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic br(input logic [31:0] t, input logic cl);
    step(0, 0, 1, t, cl, 0, 0, 0, 0);
  endtask

  task automatic do_ret();
    step(0, 0, 0, 32'h0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] tg;
    rst = 1'b1;
    bus.stall = 0; bus.br_taken = 0; bus.br_target = '0; bus.call = 0;
    bus.ret = 0; bus.exc = 0; bus.halt = 0; bus.resume = 0;

    step(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    chk("boot_pc", bus.pc, 32'h3000);
    chk("boot_valid", 32'(bus.pc_valid), 32'd0);
    chk("boot_empty", 32'(bus.ras_empty), 32'd1);
    idle(); chk("run0", bus.pc, 32'h3000); chk("run0_valid", 32'(bus.pc_valid), 32'd1);
    idle(); chk("run1", bus.pc, 32'h3004);
    idle(); chk("run2", bus.pc, 32'h3008);

    step(0, 1, 1, 32'h3100, 0, 0, 0, 0, 0); chk("stall_br", bus.pc, 32'h3008);
    br(32'h3100, 0); chk("br_after_stall", bus.pc, 32'h3100);
    br(32'h3103, 0); chk("align", bus.pc, 32'h3100);

    br(32'h3010, 0);
    br(32'h3200, 1); chk("call", bus.pc, 32'h3200);
    chk("call_empty", 32'(bus.ras_empty), 32'd0);
    idle(); chk("call+1", bus.pc, 32'h3204);
    idle(); chk("call+2", bus.pc, 32'h3208);
    do_ret(); chk("ret", bus.pc, 32'h3014);
    chk("ret_empty", 32'(bus.ras_empty), 32'd1);

    for (int i = 0; i < 5; i++) begin
      br(32'h5000 + 32'(i) * 32'h100, 1);
      if (i == 3) chk("full4", 32'(bus.ras_full), 32'd1);
    end
    chk("full5", 32'(bus.ras_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_ret();
      chk("ovf_ret", bus.pc, 32'h5304 - 32'(i) * 32'h100);
    end
    chk("ovf_empty", 32'(bus.ras_empty), 32'd1);
    do_ret(); chk("ret_on_empty", bus.pc, 32'h5008);

    br(32'h3020, 1);
    step(0, 1, 0, 32'h0, 0, 1, 1, 1, 0);
    chk("exc_pc", bus.pc, 32'h4180);
    chk("exc_valid", 32'(bus.pc_valid), 32'd1);
    chk("exc_ras", 32'(bus.ras_empty), 32'd0);
    do_ret(); chk("exc_ras_top", bus.pc, 32'h500c);

    br(32'h3030, 0);
    step(0, 0, 0, 32'h0, 0, 0, 0, 1, 0);
    chk("halt_pc", bus.pc, 32'h3030); chk("halt_valid", 32'(bus.pc_valid), 32'd0);
    idle(); chk("halt_hold", bus.pc, 32'h3030);
    step(0, 0, 0, 32'h0, 0, 0, 0, 0, 1);
    chk("resume", bus.pc, 32'h3034); chk("resume_valid", 32'(bus.pc_valid), 32'd1);

    br(32'hFFFF_FFFC, 0);
    idle(); chk("wrap", bus.pc, 32'h0);

    step(0, 0, 0, 32'h0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    chk("halt_rst_pc", bus.pc, 32'h3000); chk("halt_rst_valid", 32'(bus.pc_valid), 32'd0);
    idle(); chk("halt_rst_run", bus.pc, 32'h3000); chk("halt_rst_v", 32'(bus.pc_valid), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) tg = $urandom;
      else tg = 32'h3000 + 32'($urandom_range(1023));
      step($urandom_range(199) == 0, $urandom_range(5) == 0, $urandom_range(2) == 0, tg,
           $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(29) == 0,
           $urandom_range(19) == 0, $urandom_range(2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
